serial_adder_subtractor: RTL and testbench



---
 rtl/serial_adder_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_adder_subtractor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_subtractor.sv
// Multi-cycle two's-complement adder/subtractor, DIGIT bits per clock, LSB first.
// Optional macro ADDSUB_SAT_EN clamps the committed result on signed overflow.
//   state | meaning
//   IDLE  | waiting for start, operands captured on start
//   RUN   | one digit of the sum per clock, N clocks
//   DONE  | one-cycle done pulse, result registers valid
module serial_adder_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_a_msb;
  logic               r_b_msb;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               r_ovf;

  logic [DIGIT:0]     w_dsum;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_res;
  logic               w_last;
  logic               w_ovf;

  assign w_dsum    = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};
  // New digit enters at the MSB end so the finished word is aligned after N shifts.
  assign w_acc_nxt = (r_acc >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last    = (r_cnt == CNT_W'(N - 1));
  assign w_ovf     = (r_a_msb == r_b_msb) && (w_acc_nxt[WIDTH-1] != r_a_msb);

`ifdef ADDSUB_SAT_EN
  assign w_res = !w_ovf  ? w_acc_nxt :
                 r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_res = w_acc_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
    s    = r_s;
    cout = r_cout;
    ovf  = r_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a_sh  <= a;
      r_b_sh  <= sub ? ~b : b;
      r_carry <= sub;
      r_cnt   <= '0;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (r_state == RUN) begin
      r_a_sh  <= r_a_sh >> DIGIT;
      r_b_sh  <= r_b_sh >> DIGIT;
      r_acc   <= w_acc_nxt;
      r_carry <= w_dsum[DIGIT];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_s    <= w_res;
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Randomised bench for serial_adder_subtractor at DIGIT = 2, 1 and 8 (WIDTH = 8).
// Reference results come from plain integer arithmetic; honours ADDSUB_SAT_EN.
module tb_serial_adder_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic       sub_i = 1'b0;
  logic [7:0] a_i = 8'h00;
  logic [7:0] b_i = 8'h00;
  logic [2:0] busy_v, done_v, cout_v, ovf_v;
  logic [7:0] s_v [3];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  serial_adder_subtractor #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_i), .a(a_i), .b(b_i),
    .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_adder_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_i), .a(a_i), .b(b_i),
    .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_adder_subtractor #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_i), .a(a_i), .b(b_i),
    .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int dig(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 8;
  endfunction

  task automatic model(input logic [7:0] ea, input logic [7:0] eb, input logic esub,
                       output logic [7:0] es, output logic ec, output logic eo);
    int ia, ib, res;
    ia  = $signed(ea);
    ib  = $signed(eb);
    res = esub ? ia - ib : ia + ib;
    eo  = (res > 127) || (res < -128);
    ec  = esub ? (ea >= eb) : ((int'(ea) + int'(eb)) > 255);
    es  = esub ? ea - eb : ea + eb;
`ifdef ADDSUB_SAT_EN
    if (eo) es = (res > 0) ? 8'h7F : 8'h80;
`endif
  endtask

  // Called just after the start edge; follows the operation up to its done cycle.
  task automatic wait_result(input int d, input logic [7:0] ea, input logic [7:0] eb,
                             input logic esub, input bit hold, input string tag);
    logic [7:0] es, prev;
    logic       ec, eo;
    int         n, busy_cnt, lat;
    bit         got, held;
    model(ea, eb, esub, es, ec, eo);
    n = 8 / dig(d);
    prev = s_v[d];
    busy_cnt = 0; lat = 0; got = 1'b0; held = 1'b1;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (done_v[d]) begin
        got = 1'b1;
        lat = k - 1;
      end else begin
        if (busy_v[d]) busy_cnt++;
        if (s_v[d] !== prev) held = 1'b0;
        if (k == 1 && !hold) start_v[d] = 1'b0;
        if (hold || k == 1) begin
          a_i   = 8'($urandom);
          b_i   = 8'($urandom);
          sub_i = 1'($urandom);
        end
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'(0), 32'(1));
      start_v[d] = 1'b0;
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(n));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n));
      check({tag, "_s_held"}, 32'(held), 32'(1));
      check({tag, "_s"}, 32'(s_v[d]), 32'(es));
      check({tag, "_cout"}, 32'(cout_v[d]), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf_v[d]), 32'(eo));
      if (!hold) begin
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_v[d]), 32'(0));
      end
    end
  endtask

  task automatic run_op(input int d, input logic [7:0] ea, input logic [7:0] eb,
                        input logic esub, input string tag);
    @(negedge clk);
    a_i = ea; b_i = eb; sub_i = esub;
    start_v[d] = 1'b1;
    @(posedge clk);
    wait_result(d, ea, eb, esub, 1'b0, tag);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", 32'(busy_v[d]), 32'(0));
      check("rst_done", 32'(done_v[d]), 32'(0));
      check("rst_s", 32'(s_v[d]), 32'(0));
      check("rst_cout", 32'(cout_v[d]), 32'(0));
      check("rst_ovf", 32'(ovf_v[d]), 32'(0));
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_s", 32'(s_v[0]), 32'(0));
    check("idle_busy", 32'(busy_v[0]), 32'(0));

    for (int d = 0; d < 3; d++) begin
      run_op(d, 8'h0A, 8'h05, 1'b0, "add");
      run_op(d, 8'h7F, 8'h01, 1'b0, "ovf_pos");
      run_op(d, 8'h80, 8'h01, 1'b1, "ovf_neg");
    end
    run_op(0, 8'h0A, 8'h05, 1'b1, "sub_pos");
    run_op(0, 8'h05, 8'h0A, 1'b1, "sub_neg");

    // start held through RUN and DONE, next operation picked up in the first IDLE cycle
    @(negedge clk);
    a_i = 8'h33; b_i = 8'h44; sub_i = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    wait_result(0, 8'h33, 8'h44, 1'b0, 1'b1, "held");
    a_i = 8'h12; b_i = 8'h34; sub_i = 1'b1;
    @(negedge clk);
    check("gap_busy", 32'(busy_v[0]), 32'(0));
    check("gap_done", 32'(done_v[0]), 32'(0));
    @(posedge clk);
    wait_result(0, 8'h12, 8'h34, 1'b1, 1'b0, "next");

    // reset on the second RUN cycle
    run_op(0, 8'h0A, 8'h05, 1'b0, "pre_rst");
    @(negedge clk);
    a_i = 8'h21; b_i = 8'h11; sub_i = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy_v[0]), 32'(0));
    check("abort_done", 32'(done_v[0]), 32'(0));
    check("abort_s", 32'(s_v[0]), 32'(0));
    rst = 1'b0;
    pulses = 0;
    repeat (7) begin
      @(negedge clk);
      if (done_v[0]) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'(0));
    run_op(0, 8'h21, 8'h11, 1'b0, "after_rst");

    repeat (40) begin
      run_op($urandom_range(0, 2), 8'($urandom), 8'($urandom), 1'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
